// File: rtl/dot_accumulator_pkg.sv
// Shared constants, state encoding and sign-extension helper for the dot-product accumulator.
package dot_accumulator_pkg;

  localparam int OPERAND_W = 16;
  localparam int PRODUCT_W = 32;
  // Widest accumulator the helper can feed; callers truncate to their own width.
  localparam int SEXT_W    = 128;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_OUTPUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    RELEASE = ST_RELEASE,
    OUTPUT  = ST_OUTPUT
  } state_t;

  function automatic logic [SEXT_W-1:0] sign_extend(input logic [PRODUCT_W-1:0] p);
    return {{(SEXT_W-PRODUCT_W){p[PRODUCT_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dot_accumulator_if.sv
// Operand, multiplier and result handshake bundle; master is the accumulator side.
interface dot_accumulator_if #(
  parameter int ACC_WIDTH = 40
);
  import dot_accumulator_pkg::*;

  logic                 In_Valid;
  logic                 In_Ready;
  logic [OPERAND_W-1:0] Multiplier;
  logic [OPERAND_W-1:0] Multiplicand;
  logic                 Mul_Start;
  logic [OPERAND_W-1:0] Mul_Multiplier;
  logic [OPERAND_W-1:0] Mul_Multiplicand;
  logic [PRODUCT_W-1:0] Mul_Product;
  logic                 Mul_Done;
  logic [ACC_WIDTH-1:0] Result;
  logic                 Result_Valid;
  logic                 Result_Ready;

  modport master (
    input  In_Valid, Multiplier, Multiplicand, Mul_Product, Mul_Done, Result_Ready,
    output In_Ready, Mul_Start, Mul_Multiplier, Mul_Multiplicand, Result, Result_Valid
  );

  modport slave (
    output In_Valid, Multiplier, Multiplicand, Mul_Product, Mul_Done, Result_Ready,
    input  In_Ready, Mul_Start, Mul_Multiplier, Mul_Multiplicand, Result, Result_Valid
  );

endinterface

// File: rtl/dot_accumulator_acc_adder.sv
// Combinational sign-extend-and-add of a product into the accumulator, zero latency, no handshake.
// Wraps by default; DOT_ACCUMULATOR_SATURATE_EN clamps each add to the signed ACC_WIDTH range.
module acc_adder
  import dot_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [PRODUCT_W-1:0] product,
  output logic [ACC_WIDTH-1:0] sum
);

  logic [ACC_WIDTH-1:0] ext;
  assign ext = ACC_WIDTH'(sign_extend(product));

`ifdef DOT_ACCUMULATOR_SATURATE_EN
  logic [ACC_WIDTH:0] wide;
  assign wide = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};

  // Top two bits disagree only on signed overflow; wide[ACC_WIDTH] gives the true sign.
  always_comb begin
    sum = wide[ACC_WIDTH-1:0];
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      sum = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = acc + ext;
`endif

endmodule

// File: rtl/dot_accumulator.sv
// Sequences operand pairs through a Start/Done multiplier and accumulates LENGTH products; optional DOT_ACCUMULATOR_SATURATE_EN.
// Per term 1 + multiplier latency + 1 cycles; In_Ready low outside IDLE, Result held until Result_Ready.
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int LENGTH    = 8,
  parameter int ACC_WIDTH = 40
) (
  input logic             Clock,
  input logic             Reset,
  dot_accumulator_if.master bus
);

  localparam int CNT_W = $clog2(LENGTH + 1);

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] mul_a_q, mul_b_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_sum, result_q;
  logic [CNT_W-1:0]     count_q;
  logic                 result_vld_q;
  logic                 capture, accumulate, finish, drain;

  acc_adder #(.ACC_WIDTH(ACC_WIDTH)) u_acc_adder (
    .acc     (acc_q),
    .product (bus.Mul_Product),
    .sum     (acc_sum)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // RELEASE waits for Done to fall so Start never rises against a stale Done.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    accumulate = 1'b0;
    finish     = 1'b0;
    drain      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.In_Valid) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.Mul_Done) begin
          accumulate = 1'b1;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.Mul_Done) begin
          if (count_q == CNT_W'(LENGTH)) begin
            finish  = 1'b1;
            state_d = OUTPUT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OUTPUT: begin
        if (bus.Result_Ready) begin
          drain   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      if (capture) begin
        mul_a_q <= bus.Multiplier;
        mul_b_q <= bus.Multiplicand;
      end
      if (accumulate) begin
        acc_q   <= acc_sum;
        count_q <= count_q + CNT_W'(1);
      end
      if (finish) begin
        result_q     <= acc_q;
        result_vld_q <= 1'b1;
      end
      if (drain) begin
        result_vld_q <= 1'b0;
        acc_q        <= '0;
        count_q      <= '0;
      end
    end
  end

  assign bus.In_Ready         = (state_q == IDLE);
  assign bus.Mul_Start        = (state_q == ISSUE);
  assign bus.Mul_Multiplier   = mul_a_q;
  assign bus.Mul_Multiplicand = mul_b_q;
  assign bus.Result           = result_q;
  assign bus.Result_Valid     = result_vld_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Three accumulators (LENGTH/ACC_WIDTH 4/40, 1/40, 3/32) each paired with a behavioural Start/Done multiplier.
module tb_dot_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid[3];
  logic [15:0] op_a[3], op_b[3];
  logic        res_ready[3];
  int          lat[3], hold_extra[3];
  int          n_res[3];

  logic        in_ready[3], mul_start[3], mul_done[3], res_valid[3];
  logic [15:0] mm_a[3], mm_b[3];
  logic [39:0] res_obs[3];

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int len_of(int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 3;
  endfunction

  function automatic int aw_of(int g);
    return (g == 2) ? 32 : 40;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_inst
    localparam int LEN = (g == 0) ? 4 : (g == 1) ? 1 : 3;
    localparam int AW  = (g == 2) ? 32 : 40;

    dot_accumulator_if #(.ACC_WIDTH(AW)) bus ();

    logic        done, busy, start_d;
    logic [31:0] prod;
    int          cnt, hold;

    assign bus.In_Valid     = in_valid[g];
    assign bus.Multiplier   = op_a[g];
    assign bus.Multiplicand = op_b[g];
    assign bus.Result_Ready = res_ready[g];
    assign bus.Mul_Product  = prod;
    assign bus.Mul_Done     = done;

    assign in_ready[g]  = bus.In_Ready;
    assign mul_start[g] = bus.Mul_Start;
    assign mul_done[g]  = done;
    assign res_valid[g] = bus.Result_Valid;
    assign mm_a[g]      = bus.Mul_Multiplier;
    assign mm_b[g]      = bus.Mul_Multiplicand;
    assign res_obs[g]   = 40'(bus.Result);

    dot_accumulator #(.LENGTH(LEN), .ACC_WIDTH(AW)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
    );

    // Multiplier: Done after lat cycles, held while Start is high, dropped hold_extra+1 cycles after Start falls.
    always @(posedge clk) begin
      if (rst) begin
        done <= 1'b0; busy <= 1'b0; cnt <= 0; hold <= 0; prod <= '0;
      end else begin
        if (!done && !busy && bus.Mul_Start) begin
          busy <= 1'b1;
          cnt  <= lat[g];
          prod <= 32'(int'($signed(bus.Mul_Multiplier)) * int'($signed(bus.Mul_Multiplicand)));
        end
        if (busy) begin
          if (cnt <= 1) begin done <= 1'b1; busy <= 1'b0; end
          else cnt <= cnt - 1;
        end
        if (done && !bus.Mul_Start) begin
          if (hold >= hold_extra[g]) begin done <= 1'b0; hold <= 0; end
          else hold <= hold + 1;
        end
      end
    end

    always @(posedge clk) begin
      if (!rst && bus.Result_Valid && bus.Result_Ready) n_res[g] <= n_res[g] + 1;
    end

    always @(negedge clk) begin
      if (rst) begin
        start_d <= 1'b0;
      end else begin
        start_d <= bus.Mul_Start;
        if (bus.Mul_Start && !start_d) check_val("start_while_done", done, 0);
        if (done) check_val("ready_while_done", bus.In_Ready, 0);
      end
    end
  end

  function automatic logic [39:0] ref_dot(int aw, input int a[$], input int b[$]);
    longint acc = 0;
    longint lim = longint'(1) << (aw - 1);
    for (int i = 0; i < a.size(); i++) begin
      acc += longint'(a[i]) * longint'(b[i]);
`ifdef DOT_ACCUMULATOR_SATURATE_EN
      if (acc > lim - 1) acc = lim - 1;
      if (acc < -lim)    acc = -lim;
`else
      acc = acc & ((lim << 1) - 1);
      if (acc >= lim) acc -= (lim << 1);
`endif
    end
    return 40'(acc & ((lim << 1) - 1));
  endfunction

  task automatic feed(int g, logic [15:0] a, logic [15:0] b);
    int n = 0;
    @(negedge clk);
    in_valid[g] = 1'b1; op_a[g] = a; op_b[g] = b;
    res_ready[g] = 1'($urandom_range(0, 1));
    while (!in_ready[g] && n < 400) begin @(negedge clk); n++; end
    check_val("accept", in_ready[g], 1);
    @(posedge clk); #1;
    in_valid[g] = 1'b0; res_ready[g] = 1'b0;
  endtask

  task automatic get_result(int g, output logic [39:0] r);
    int n = 0;
    @(negedge clk);
    res_ready[g] = 1'b0;
    while (!res_valid[g] && n < 400) begin @(negedge clk); n++; end
    check_val("result_valid", res_valid[g], 1);
    r = res_obs[g];
    res_ready[g] = 1'b1;
    @(posedge clk); #1;
    res_ready[g] = 1'b0;
  endtask

  task automatic run_set(int g, input int a[$], input int b[$], output logic [39:0] r);
    for (int i = 0; i < a.size(); i++) feed(g, 16'(a[i]), 16'(b[i]));
    get_result(g, r);
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 5))
      0:       return 32767;
      1:       return -32768;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  task automatic rand_set(int g, int len, output int a[$], output int b[$]);
    a = {}; b = {};
    for (int i = 0; i < len; i++) begin
      a.push_back(rand_op());
      b.push_back(rand_op());
    end
  endtask

  task automatic check_reset(int g);
    check_val("rst_in_ready", in_ready[g], 1);
    check_val("rst_mul_start", mul_start[g], 0);
    check_val("rst_mul_a", mm_a[g], 0);
    check_val("rst_mul_b", mm_b[g], 0);
    check_val("rst_result_valid", res_valid[g], 0);
    check_val("rst_result", res_obs[g], 0);
  endtask

  initial begin
    int qa[$], qb[$];
    logic [39:0] r, r0;
    int n0, n;

    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 0; op_a[g] = 0; op_b[g] = 0; res_ready[g] = 0;
      lat[g] = 2; hold_extra[g] = 0; n_res[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) check_reset(g);

    // Directed sums with known answers
    lat[0] = 3;
    n0 = n_res[0];
    qa = {3, -5, 7, -2}; qb = {4, 6, -8, -9};
    run_set(0, qa, qb, r);
    check_val("dot4_const", r, 40'hFFFFFFFFC8);
    check_val("dot4_model", r, ref_dot(40, qa, qb));
    repeat (3) @(negedge clk);
    check_val("dot4_once", n_res[0] - n0, 1);

    qa = {32767}; qb = {32767};
    run_set(1, qa, qb, r);
    check_val("len1_max", r, 40'h003FFF0001);

    qa = {32767, 32767, 32767}; qb = {32767, 32767, 32767};
    run_set(2, qa, qb, r);
`ifdef DOT_ACCUMULATOR_SATURATE_EN
    check_val("w32_sat", r, 40'h007FFFFFFF);
`else
    check_val("w32_wrap", r, 40'h00BFFD0003);
`endif

    // Consumer stalls with a pending result while the source keeps offering
    rand_set(0, 4, qa, qb);
    for (int i = 0; i < 4; i++) feed(0, 16'(qa[i]), 16'(qb[i]));
    n = 0;
    @(negedge clk);
    while (!res_valid[0] && n < 400) begin @(negedge clk); n++; end
    r0 = res_obs[0];
    check_val("stall_result", r0, ref_dot(40, qa, qb));
    in_valid[0] = 1'b1; op_a[0] = 16'h1234; op_b[0] = 16'h0777;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("stall_in_ready", in_ready[0], 0);
      check_val("stall_mul_start", mul_start[0], 0);
      check_val("stall_valid", res_valid[0], 1);
    end
    check_val("stall_stable", res_obs[0], r0);
    in_valid[0] = 1'b0;
    res_ready[0] = 1'b1;
    @(posedge clk); #1 res_ready[0] = 1'b0;
    rand_set(0, 4, qa, qb);
    run_set(0, qa, qb, r);
    check_val("after_stall", r, ref_dot(40, qa, qb));

    // Reset while the second term is in flight
    feed(0, 16'd100, 16'd200);
    feed(0, 16'd300, 16'd400);
    @(negedge clk);
    check_val("in_issue", mul_start[0], 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset(0);
    rand_set(0, 4, qa, qb);
    run_set(0, qa, qb, r);
    check_val("after_reset", r, ref_dot(40, qa, qb));

    // Done lingers three extra cycles after Start drops
    hold_extra[0] = 3;
    rand_set(0, 4, qa, qb);
    run_set(0, qa, qb, r);
    check_val("slow_done", r, ref_dot(40, qa, qb));

    for (int it = 0; it < 6; it++) begin
      for (int g = 0; g < 3; g++) begin
        lat[g] = $urandom_range(1, 4);
        hold_extra[g] = $urandom_range(0, 2);
        rand_set(g, len_of(g), qa, qb);
        run_set(g, qa, qb, r);
        check_val("random_set", r, ref_dot(aw_of(g), qa, qb));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Downstream consumer and sequencer for the 16x16 signed sequential multiplier, which has a Start/Done level handshake and a 32-bit Product.
- Accepts a stream of operand pairs, issues each pair to the multiplier, and sign-extends and accumulates each product.
- After LENGTH products, presents the dot-product result with a valid/ready handshake.
- Sits between the operand source and the result consumer of the arithmetic datapath.

Parameters:
- LENGTH, 8: number of products per dot product; must be ≥1.
- ACC_WIDTH, 40: accumulator/result width; must be ≥32.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset. The multiplier is driven by the same Reset.
- In_Valid  input  1  operand pair valid.
- In_Ready  output  1  block can accept an operand pair.
- Multiplier  input  16  signed operand A.
- Multiplicand  input  16  signed operand B.
- Mul_Start  output  1  Start level to the multiplier.
- Mul_Multiplier  output  16  registered operand A to the multiplier.
- Mul_Multiplicand  output  16  registered operand B to the multiplier.
- Mul_Product  input  32  signed product from the multiplier.
- Mul_Done  input  1  Done level from the multiplier.
- Result  output  ACC_WIDTH  signed dot-product result.
- Result_Valid  output  1  Result valid.
- Result_Ready  input  1  consumer accepts Result.

Behaviour:
- Reset values: state=IDLE, In_Ready=1, Mul_Start=0, Mul_Multiplier=0, Mul_Multiplicand=0, Result=0, Result_Valid=0, accumulator=0, term count=0.
- Reset mid-operation: reset has priority; everything returns to reset values on the next edge, and any in-flight product is discarded.
- States are IDLE, ISSUE, RELEASE and OUTPUT. Transitions per cycle:
  - IDLE: In_Ready=1. When In_Valid=1, capture both operands into the Mul_* registers and go to ISSUE.
  - ISSUE: Mul_Start=1, In_Ready=0. Stay until Mul_Done=1. On the edge where Mul_Done=1:
    - add the sign-extended Mul_Product to the accumulator;
    - increment the count;
    - go to RELEASE.
  - RELEASE: Mul_Start=0. Stay while Mul_Done=1; the multiplier holds Done until Start drops and clears it one cycle later. When Mul_Done=0:
    - if count==LENGTH, go to OUTPUT, with Result = accumulator and Result_Valid=1 registered on that edge;
    - otherwise go to IDLE.
  - OUTPUT: Result_Valid=1, Result stable, In_Ready=0. When Result_Ready=1, go to IDLE with Result_Valid=0, accumulator=0, count=0 on that edge. Result keeps its last value.
- A new operand is never issued while Mul_Done=1. This is the 4-phase handshake: Start↑, Done↑, Start↓, Done↓.
- Arithmetic:
  - Mul_Product is treated as two's-complement and sign-extended to ACC_WIDTH.
  - The accumulator add wraps modulo 2^ACC_WIDTH unless the optional feature is enabled.
- Boundaries:
  - LENGTH=1: each pair produces one result.
  - Result_Ready held low: OUTPUT holds indefinitely and no input is accepted.
  - In_Valid during ISSUE, RELEASE or OUTPUT: ignored, since In_Ready=0.
  - A Result_Ready pulse outside OUTPUT has no effect.
- Latency per term: 1 (capture) + multiplier latency + 1 (release) cycles. The result is valid on the cycle after the last term's release.

Optional Feature:
- DOT_ACCUMULATOR_SATURATE_EN defined:
  - each add saturates to the signed ACC_WIDTH range: max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1);
  - once saturated, the accumulator may move back off the rail on later adds.
- Undefined: wrapping add. No extra ports either way.

Decomposition:
- Shared arithmetic package:
  - state encoding localparams (IDLE, ISSUE, RELEASE, OUTPUT);
  - operand width 16 and product width 32 constants;
  - a sign-extension helper.
- One natural sub-module: acc_adder, the combinational sign-extend plus wrap-or-saturate adder. It is parameterised by ACC_WIDTH and contains the SATURATE_EN conditional.

Test Plan:
- LENGTH=4, pairs (3,4), (-5,6), (7,-8), (-2,-9) against a real multiplier -> Result = -56 (0xFFFFFFFFC8 at 40 bits), Result_Valid=1 once.
- LENGTH=1, pair (0x7FFF,0x7FFF) -> Result = 0x003FFF0001. Mul_Start never rises again before Mul_Done has fallen.
- ACC_WIDTH=32, LENGTH=3, three pairs (0x7FFF,0x7FFF) -> wrap build gives Result=0xBFFD0003; SATURATE_EN build gives 0x7FFFFFFF.
- Result_Ready held low for 20 cycles with In_Valid=1 -> Result stable, In_Ready=0, no Mul_Start. Release Result_Ready -> the next set starts from accumulator 0.
- Reset asserted for one cycle while in ISSUE on term 2 -> next cycle all outputs are at reset values. A fresh LENGTH-term set then gives the correct sum, with no carryover.
- Mul_Done model that holds Done for 3 extra cycles after Start drops -> block stays in RELEASE and issues the next term only after Done=0.
